// File: rtl/mem_32x8_pkg.sv
// mem_32x8_pkg: shared RAM geometry so the CPU address mux and the RAM agree
package mem_32x8_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_W;
endpackage

// File: rtl/mem_32x8_if.sv
// mem_32x8_if: address and strobe signals between the CPU controller and the RAM
interface mem_32x8_if
  import mem_32x8_pkg::*;
#(
  parameter int AW = ADDR_W
);
  logic [AW-1:0] addr;
  logic          read;
  logic          write;
  modport master (output addr, output read, output write);
  modport slave  (input addr, input read, input write);
endinterface

// File: rtl/mem_32x8.sv
// mem_32x8: synchronous-write, asynchronous-read RAM on the CPU's shared tri-state data bus
module mem_32x8
  import mem_32x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_32x8_if.slave         bus,
  inout  wire  [DATA_W-1:0] data
);
  logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];
  logic              w_we;
  // the bus carries our own output while read is high, so a read blocks the write
  assign w_we = bus.write & ~bus.read & ~rst;
  assign data = bus.read ? r_mem[bus.addr] : {DATA_W{1'bz}};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[bus.addr] <= data;
    end
  end
endmodule

// File: tb/tb_mem_32x8.sv
// tb_mem_32x8: directed scoreboard bench for the 32x8 bus RAM
module tb_mem_32x8;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] drv = '0;
  logic       drv_en = 1'b0;
  wire  [7:0] data;
  logic [7:0] sb [$];
  logic [7:0] exp_v;
  int         n_vec = 0;
  int         n_err = 0;

  mem_32x8_if bus ();
  mem_32x8 dut (.clk(clk), .rst(rst), .bus(bus), .data(data));

  assign data = drv_en ? drv : 8'hzz;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr = a; bus.read = 1'b0; bus.write = 1'b1; drv = d; drv_en = 1'b1;
    @(posedge clk);
    #1;
    bus.write = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] e);
    @(negedge clk);
    bus.addr = a; bus.read = 1'b1; bus.write = 1'b0; drv_en = 1'b0;
    sb.push_back(e);
    #1;
    exp_v = sb.pop_front();
    n_vec++;
    assert (data === exp_v) else begin
      n_err++;
      $error("FAIL %s addr=%0d observed=%h expected=%h", tag, a, data, exp_v);
    end
    bus.read = 1'b0;
  endtask

  initial begin
    bus.addr = '0; bus.read = 1'b0; bus.write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rd("reset", 5'(i), 8'h00);
    for (int i = 0; i < 32; i++) wr(5'(i), 8'(i));
    for (int i = 0; i < 32; i++) rd("wr_rd", 5'(i), 8'(i));
    @(negedge clk);
    bus.addr = 5'd9; bus.read = 1'b0; drv_en = 1'b0;
    #1;
    n_vec++;
    assert (data === 8'hzz) else begin
      n_err++;
      $error("FAIL hiz observed=%h expected=zz", data);
    end
    drv = 8'h5A; drv_en = 1'b1;
    #1;
    n_vec++;
    assert (data === 8'h5A) else begin
      n_err++;
      $error("FAIL ext_drive observed=%h expected=5a", data);
    end
    drv_en = 1'b0;
    wr(5'd5, 8'hA5);
    @(negedge clk);
    bus.addr = 5'd5; bus.read = 1'b1; bus.write = 1'b1; drv = 8'h3C; drv_en = 1'b1;
    @(posedge clk);
    #1;
    bus.read = 1'b0; bus.write = 1'b0; drv_en = 1'b0;
    rd("rd_wr_collide", 5'd5, 8'hA5);
    wr(5'd31, 8'h11);
    wr(5'd31, 8'h22);
    rd("last_write_wins", 5'd31, 8'h22);
    rd("neighbour_kept", 5'd30, 8'd30);
    @(negedge clk);
    rst = 1'b1; bus.addr = 5'd7; bus.write = 1'b1; drv = 8'hFF; drv_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; bus.write = 1'b0; drv_en = 1'b0;
    rd("rst_over_write", 5'd7, 8'h00);
    rd("rst_clears_0", 5'd0, 8'h00);
    rd("rst_clears_31", 5'd31, 8'h00);
    rd("rst_clears_5", 5'd5, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
